// File: rtl/axis_hdr_insert_q.sv
// AXI-Stream header inserter: queues up to HDR_DEPTH headers, prepends one to each
// packet and repacks header+payload bytes MSB-first into full beats without bubbles.
module axis_hdr_insert_q #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int HDR_DEPTH    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  input  logic                    valid_insert,
  input  logic [DATA_WD-1:0]      header_insert,
  input  logic [DATA_BYTE_WD-1:0] keep_insert,
  output logic                    ready_insert,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out
);

  localparam int CNT_W = BYTE_CNT_WD + 1;
  localparam int SUM_W = CNT_W + 1;
  localparam int AW    = (HDR_DEPTH > 1) ? $clog2(HDR_DEPTH) : 1;
  localparam int QC_W  = $clog2(HDR_DEPTH + 1);
  localparam logic [CNT_W-1:0] N_C = CNT_W'(DATA_BYTE_WD);

  typedef enum logic [1:0] {IDLE, STREAM, TAIL} state_t;

  function automatic logic [CNT_W-1:0] popcnt(input logic [DATA_BYTE_WD-1:0] k);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) c = c + CNT_W'(k[i]);
    return c;
  endfunction

  function automatic logic [DATA_BYTE_WD-1:0] keep_top(input logic [SUM_W-1:0] k);
    return ~({DATA_BYTE_WD{1'b1}} >> k);
  endfunction

  function automatic logic [DATA_WD-1:0] byte_mask(input logic [DATA_BYTE_WD-1:0] k);
    logic [DATA_WD-1:0] m;
    for (int i = 0; i < DATA_BYTE_WD; i++) m[i*8 +: 8] = {8{k[i]}};
    return m;
  endfunction

  function automatic logic [DATA_WD-1:0] shl_bytes(input logic [DATA_WD-1:0] d,
                                                   input logic [SUM_W-1:0] n);
    return d << {n, 3'b000};
  endfunction

  function automatic logic [DATA_WD-1:0] shr_bytes(input logic [DATA_WD-1:0] d,
                                                   input logic [SUM_W-1:0] n);
    return d >> {n, 3'b000};
  endfunction

  state_t state_q, state_nxt;

  logic [DATA_WD-1:0] hdr_mem [HDR_DEPTH];
  logic [CNT_W-1:0]   len_mem [HDR_DEPTH];
  logic [AW-1:0]      wr_idx, rd_idx;
  logic [QC_W-1:0]    q_cnt;
  logic               push, pop;

  logic [DATA_WD-1:0] res_dat;
  logic [CNT_W-1:0]   res_cnt;

  logic                    ld_p0, acc;
  logic [DATA_WD-1:0]      data_m;
  logic [CNT_W-1:0]        l_cnt;
  logic [SUM_W-1:0]        sum;
  logic                    vld_p0, last_p0;
  logic [DATA_WD-1:0]      dat_p0;
  logic [DATA_BYTE_WD-1:0] keep_p0;

  // Full blocks pushes even when the FSM pops the same cycle.
  assign ready_insert = (q_cnt != QC_W'(HDR_DEPTH));
  assign push         = valid_insert && ready_insert;

  always_ff @(posedge clk) begin
    if (push) begin
      hdr_mem[wr_idx] <= header_insert;
      len_mem[wr_idx] <= popcnt(keep_insert);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx <= '0;
      rd_idx <= '0;
      q_cnt  <= '0;
    end else begin
      if (push) wr_idx <= (wr_idx == AW'(HDR_DEPTH - 1)) ? '0 : wr_idx + 1'b1;
      if (pop)  rd_idx <= (rd_idx == AW'(HDR_DEPTH - 1)) ? '0 : rd_idx + 1'b1;
      q_cnt <= q_cnt + QC_W'(push) - QC_W'(pop);
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (q_cnt != '0) state_nxt = STREAM;
      STREAM:  if (acc && last_in) state_nxt = (sum <= SUM_W'(N_C)) ? IDLE : TAIL;
      TAIL:    if (ld_p0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: merge residual bytes with the incoming beat
  always_comb begin
    ld_p0    = !valid_out || ready_out;
    ready_in = (state_q == STREAM) && ld_p0;
    acc      = valid_in && ready_in;
    pop      = (state_q == IDLE) && (q_cnt != '0);
    data_m   = data_in & byte_mask(keep_in);
    l_cnt    = last_in ? popcnt(keep_in) : N_C;
    sum      = SUM_W'(res_cnt) + SUM_W'(l_cnt);
    vld_p0   = 1'b0;
    dat_p0   = '0;
    keep_p0  = '0;
    last_p0  = 1'b0;
    case (state_q)
      STREAM: begin
        if (acc) begin
          vld_p0 = 1'b1;
          dat_p0 = res_dat | shr_bytes(data_m, SUM_W'(res_cnt));
          if (last_in && (sum <= SUM_W'(N_C))) begin
            keep_p0 = keep_top(sum);
            last_p0 = 1'b1;
          end else begin
            keep_p0 = '1;
          end
        end
      end
      TAIL: begin
        vld_p0  = 1'b1;
        dat_p0  = res_dat;
        keep_p0 = keep_top(SUM_W'(res_cnt));
        last_p0 = 1'b1;
      end
      default: ;
    endcase
  end

  // Residual holds res_cnt bytes left-aligned; lower bytes are always zero.
  always_ff @(posedge clk) begin
    if (pop)      res_dat <= shl_bytes(hdr_mem[rd_idx], SUM_W'(N_C - len_mem[rd_idx]));
    else if (acc) res_dat <= shl_bytes(data_m, SUM_W'(N_C - res_cnt));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_cnt <= '0;
    end else if (pop) begin
      res_cnt <= len_mem[rd_idx];
    end else if (acc && last_in && (sum > SUM_W'(N_C))) begin
      res_cnt <= CNT_W'(sum - SUM_W'(N_C));
    end
  end

  // Stage p1: output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      keep_out  <= '0;
      last_out  <= 1'b0;
    end else if (ld_p0) begin
      valid_out <= vld_p0;
      data_out  <= dat_p0;
      keep_out  <= keep_p0;
      last_out  <= last_p0;
    end
  end

endmodule

// File: tb/tb_axis_hdr_insert_q.sv
// Bench for axis_hdr_insert_q: directed cases plus randomized packets checked
// against a byte-queue reference model.
module tb_axis_hdr_insert_q;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] data_in;
  logic [3:0]  keep_in;
  logic        last_in;
  logic        ready_in;
  logic        valid_insert;
  logic [31:0] header_insert;
  logic [3:0]  keep_insert;
  logic        ready_insert;
  logic        valid_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        last_out;
  logic        ready_out;

  int checks = 0;
  int failures = 0;
  int timeouts = 0;
  int stab_err = 0;
  bit bp_en = 0;

  beat_t got_q[$];
  beat_t exp_q[$];
  beat_t pay_q[$];
  beat_t pkt_q[$];
  logic [31:0] hq_d[$];
  logic [3:0]  hq_k[$];

  axis_hdr_insert_q #(.DATA_WD(32), .HDR_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
    .ready_in(ready_in),
    .valid_insert(valid_insert), .header_insert(header_insert),
    .keep_insert(keep_insert), .ready_insert(ready_insert),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out),
    .last_out(last_out), .ready_out(ready_out)
  );

  always #5 clk = ~clk;

  initial begin
    ready_out = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ready_out = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output collector and hold-stability observer.
  initial begin
    logic [37:0] prev_val;
    bit prev_stall;
    prev_stall = 0;
    prev_val = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
      end else begin
        if (prev_stall && ({valid_out, data_out, keep_out, last_out} !== prev_val)) stab_err++;
        prev_stall = valid_out && !ready_out;
        prev_val = {valid_out, data_out, keep_out, last_out};
        if (valid_out && ready_out) got_q.push_back('{data_out, keep_out, last_out});
      end
    end
  end

  task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    bit hs;
    hs = 0;
    valid_in = 1'b1; data_in = d; keep_in = k; last_in = l;
    for (int c = 0; c < 2000 && !hs; c++) begin
      @(negedge clk);
      hs = ready_in;
      @(posedge clk);
      #1;
    end
    if (!hs) timeouts++;
    valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
  endtask

  task automatic push_hdr(input logic [31:0] d, input logic [3:0] k);
    bit hs;
    hs = 0;
    valid_insert = 1'b1; header_insert = d; keep_insert = k;
    for (int c = 0; c < 2000 && !hs; c++) begin
      @(negedge clk);
      hs = ready_insert;
      @(posedge clk);
      #1;
    end
    if (!hs) timeouts++;
    valid_insert = 1'b0; header_insert = '0; keep_insert = '0;
  endtask

  task automatic send_pay(input bit gaps);
    beat_t b;
    while (pay_q.size() > 0) begin
      b = pay_q.pop_front();
      drive_beat(b.d, b.k, b.l);
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_out(input int n);
    int c;
    c = 0;
    while (got_q.size() < n && c < 3000) begin
      @(posedge clk);
      #1;
      c++;
    end
    if (got_q.size() < n) timeouts++;
    repeat (6) @(posedge clk);
    #1;
  endtask

  // Reference: header's H low bytes then payload bytes, chopped into N-byte beats.
  function automatic void model_pkt(input logic [31:0] hd, input logic [3:0] hk);
    logic [7:0] bq[$];
    int h, n, m;
    beat_t e;
    h = $countones(hk);
    for (int i = h - 1; i >= 0; i--) bq.push_back(hd[i*8 +: 8]);
    foreach (pkt_q[j]) begin
      n = pkt_q[j].l ? $countones(pkt_q[j].k) : 4;
      for (int i = 3; i >= 4 - n; i--) bq.push_back(pkt_q[j].d[i*8 +: 8]);
    end
    while (bq.size() > 0) begin
      m = (bq.size() > 4) ? 4 : bq.size();
      e.d = '0;
      for (int j = 0; j < m; j++) e.d[31 - 8*j -: 8] = bq.pop_front();
      e.k = 4'(4'hF << (4 - m));
      e.l = (bq.size() == 0);
      exp_q.push_back(e);
    end
  endfunction

  task automatic gen_rand_pkt();
    int h, nb, l;
    logic [31:0] hd;
    logic [3:0] hk;
    beat_t b;
    h = $urandom_range(1, 4);
    hk = 4'(4'hF >> (4 - h));
    hd = $urandom;
    hq_d.push_back(hd);
    hq_k.push_back(hk);
    pkt_q.delete();
    nb = $urandom_range(1, 4);
    for (int i = 0; i < nb; i++) begin
      b.d = $urandom;
      b.l = (i == nb - 1);
      l = $urandom_range(1, 4);
      b.k = b.l ? 4'(4'hF << (4 - l)) : 4'hF;
      pkt_q.push_back(b);
      pay_q.push_back(b);
    end
    model_pkt(hd, hk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid_out got=%b exp=0", valid_out); end
    checks++; if (data_out !== 32'h0) begin failures++; $display("FAIL reset_data_out got=%h exp=0", data_out); end
    checks++; if (keep_out !== 4'h0) begin failures++; $display("FAIL reset_keep_out got=%b exp=0", keep_out); end
    checks++; if (last_out !== 1'b0) begin failures++; $display("FAIL reset_last_out got=%b exp=0", last_out); end
    checks++; if (ready_in !== 1'b0) begin failures++; $display("FAIL reset_ready_in got=%b exp=0", ready_in); end
    checks++; if (ready_insert !== 1'b1) begin failures++; $display("FAIL reset_ready_insert got=%b exp=1", ready_insert); end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ready_in !== 1'b0) begin failures++; $display("FAIL idle_ready_in got=%b exp=0", ready_in); end
  endtask

  task automatic test_short_tail();
    got_q.delete(); exp_q.delete(); timeouts = 0;
    exp_q.push_back('{32'h3344AABB, 4'b1111, 1'b0});
    exp_q.push_back('{32'hCCDDEEFF, 4'b1111, 1'b1});
    fork
      push_hdr(32'h11223344, 4'b0011);
      begin
        drive_beat(32'hAABBCCDD, 4'b1111, 1'b0);
        checks++;
        if (valid_out !== 1'b1 || data_out !== 32'h3344AABB) begin
          failures++; $display("FAIL short_tail_latency got=%b/%h exp=1/3344aabb", valid_out, data_out);
        end
        drive_beat(32'hEEFF0011, 4'b1100, 1'b1);
      end
    join
    wait_out(exp_q.size());
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL short_tail_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL short_tail beat%0d got=%h/%b/%b exp=%h/%b/%b", i, got_q[i].d, got_q[i].k, got_q[i].l, exp_q[i].d, exp_q[i].k, exp_q[i].l); end
    end
    checks++; if (timeouts !== 0) begin failures++; $display("FAIL short_tail_timeout got=%0d exp=0", timeouts); end
  endtask

  task automatic test_tail_overflow();
    got_q.delete(); exp_q.delete(); timeouts = 0;
    exp_q.push_back('{32'h3344AABB, 4'b1111, 1'b0});
    exp_q.push_back('{32'hCCDDEEFF, 4'b1111, 1'b0});
    exp_q.push_back('{32'h99000000, 4'b1000, 1'b1});
    fork
      push_hdr(32'h11223344, 4'b0011);
      begin
        drive_beat(32'hAABBCCDD, 4'b1111, 1'b0);
        drive_beat(32'hEEFF9911, 4'b1110, 1'b1);
      end
    join
    wait_out(exp_q.size());
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL tail_overflow_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL tail_overflow beat%0d got=%h/%b/%b exp=%h/%b/%b", i, got_q[i].d, got_q[i].k, got_q[i].l, exp_q[i].d, exp_q[i].k, exp_q[i].l); end
    end
    checks++; if (timeouts !== 0) begin failures++; $display("FAIL tail_overflow_timeout got=%0d exp=0", timeouts); end
  endtask

  task automatic test_full_header();
    got_q.delete(); exp_q.delete(); timeouts = 0;
    exp_q.push_back('{32'hDEADBEEF, 4'b1111, 1'b0});
    exp_q.push_back('{32'h01000000, 4'b1000, 1'b1});
    fork
      push_hdr(32'hDEADBEEF, 4'b1111);
      drive_beat(32'h01020304, 4'b1000, 1'b1);
    join
    wait_out(exp_q.size());
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL full_header_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL full_header beat%0d got=%h/%b/%b exp=%h/%b/%b", i, got_q[i].d, got_q[i].k, got_q[i].l, exp_q[i].d, exp_q[i].k, exp_q[i].l); end
    end
    checks++; if (timeouts !== 0) begin failures++; $display("FAIL full_header_timeout got=%0d exp=0", timeouts); end
  endtask

  task automatic test_queue_fill();
    int seen_ready;
    bit reasserted;
    got_q.delete(); exp_q.delete(); pay_q.delete(); hq_d.delete(); hq_k.delete(); timeouts = 0;
    for (int p = 0; p < 3; p++) gen_rand_pkt();
    // The first header moves straight into the FSM, so two pushes leave room.
    push_hdr(hq_d[0], hq_k[0]);
    push_hdr(hq_d[1], hq_k[1]);
    checks++; if (ready_insert !== 1'b1) begin failures++; $display("FAIL fill_after2 got=%b exp=1", ready_insert); end
    push_hdr(hq_d[2], hq_k[2]);
    checks++; if (ready_insert !== 1'b0) begin failures++; $display("FAIL fill_full got=%b exp=0", ready_insert); end
    seen_ready = 0;
    valid_insert = 1'b1; header_insert = 32'hFFFFFFFF; keep_insert = 4'b1111;
    repeat (4) begin
      @(negedge clk);
      if (ready_insert) seen_ready++;
      @(posedge clk);
      #1;
    end
    valid_insert = 1'b0; header_insert = '0; keep_insert = '0;
    checks++; if (seen_ready !== 0) begin failures++; $display("FAIL fill_hold got=%0d exp=0", seen_ready); end
    reasserted = 0;
    fork
      send_pay(1'b0);
      for (int c = 0; c < 200 && !reasserted; c++) begin
        @(negedge clk);
        if (ready_insert) reasserted = 1;
      end
    join
    wait_out(exp_q.size());
    checks++; if (reasserted !== 1'b1) begin failures++; $display("FAIL fill_reassert got=%b exp=1", reasserted); end
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL fill_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL fill beat%0d got=%h/%b/%b exp=%h/%b/%b", i, got_q[i].d, got_q[i].k, got_q[i].l, exp_q[i].d, exp_q[i].k, exp_q[i].l); end
    end
    checks++; if (timeouts !== 0) begin failures++; $display("FAIL fill_timeout got=%0d exp=0", timeouts); end
  endtask

  task automatic test_backpressure();
    got_q.delete(); exp_q.delete(); timeouts = 0; stab_err = 0;
    exp_q.push_back('{32'h3344AABB, 4'b1111, 1'b0});
    exp_q.push_back('{32'hCCDDEEFF, 4'b1111, 1'b1});
    bp_en = 1;
    for (int rep = 0; rep < 4; rep++) begin
      fork
        push_hdr(32'h11223344, 4'b0011);
        begin
          drive_beat(32'hAABBCCDD, 4'b1111, 1'b0);
          drive_beat(32'hEEFF0011, 4'b1100, 1'b1);
        end
      join
      if (rep < 3) begin
        exp_q.push_back('{32'h3344AABB, 4'b1111, 1'b0});
        exp_q.push_back('{32'hCCDDEEFF, 4'b1111, 1'b1});
      end
    end
    wait_out(exp_q.size());
    bp_en = 0;
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL bp_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL bp beat%0d got=%h/%b/%b exp=%h/%b/%b", i, got_q[i].d, got_q[i].k, got_q[i].l, exp_q[i].d, exp_q[i].k, exp_q[i].l); end
    end
    checks++; if (stab_err !== 0) begin failures++; $display("FAIL bp_stable got=%0d exp=0", stab_err); end
    checks++; if (timeouts !== 0) begin failures++; $display("FAIL bp_timeout got=%0d exp=0", timeouts); end
  endtask

  task automatic test_random();
    got_q.delete(); exp_q.delete(); pay_q.delete(); hq_d.delete(); hq_k.delete();
    timeouts = 0; stab_err = 0;
    for (int p = 0; p < 24; p++) gen_rand_pkt();
    bp_en = 1;
    fork
      foreach (hq_d[i]) begin
        push_hdr(hq_d[i], hq_k[i]);
        if ($urandom_range(0, 2) == 0) begin
          @(posedge clk);
          #1;
        end
      end
      send_pay(1'b1);
    join
    wait_out(exp_q.size());
    bp_en = 0;
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL random_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL random beat%0d got=%h/%b/%b exp=%h/%b/%b", i, got_q[i].d, got_q[i].k, got_q[i].l, exp_q[i].d, exp_q[i].k, exp_q[i].l); end
    end
    checks++; if (stab_err !== 0) begin failures++; $display("FAIL random_stable got=%0d exp=0", stab_err); end
    checks++; if (timeouts !== 0) begin failures++; $display("FAIL random_timeout got=%0d exp=0", timeouts); end
  endtask

  task automatic test_reset_mid();
    int rdy_seen;
    got_q.delete(); exp_q.delete(); timeouts = 0;
    push_hdr(32'h11223344, 4'b0011);
    push_hdr(32'h55667788, 4'b0111);
    drive_beat(32'hAABBCCDD, 4'b1111, 1'b0);
    valid_in = 1'b1; data_in = 32'h01234567; keep_in = 4'b1111; last_in = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%b exp=0", valid_out); end
    checks++; if (data_out !== 32'h0) begin failures++; $display("FAIL rst_mid_data got=%h exp=0", data_out); end
    checks++; if ({keep_out, last_out, ready_in} !== 6'b0) begin failures++; $display("FAIL rst_mid_ctrl got=%b exp=000000", {keep_out, last_out, ready_in}); end
    valid_in = 1'b0; data_in = '0; keep_in = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    got_q.delete();
    checks++; if (ready_insert !== 1'b1) begin failures++; $display("FAIL rst_mid_ready_insert got=%b exp=1", ready_insert); end
    rdy_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (ready_in || valid_out) rdy_seen++;
      @(posedge clk);
      #1;
    end
    checks++; if (rdy_seen !== 0) begin failures++; $display("FAIL rst_mid_idle got=%0d exp=0", rdy_seen); end
    exp_q.push_back('{32'hA1B2C3D4, 4'b1111, 1'b0});
    exp_q.push_back('{32'hE5000000, 4'b1000, 1'b1});
    fork
      push_hdr(32'h00A1B2C3, 4'b0111);
      drive_beat(32'hD4E5F607, 4'b1100, 1'b1);
    join
    wait_out(exp_q.size());
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rst_mid_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rst_mid beat%0d got=%h/%b/%b exp=%h/%b/%b", i, got_q[i].d, got_q[i].k, got_q[i].l, exp_q[i].d, exp_q[i].k, exp_q[i].l); end
    end
    checks++; if (timeouts !== 0) begin failures++; $display("FAIL rst_mid_timeout got=%0d exp=0", timeouts); end
  endtask

  initial begin
    rst = 1'b1;
    valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
    valid_insert = 1'b0; header_insert = '0; keep_insert = '0;
    test_reset();
    test_short_tail();
    test_tail_overflow();
    test_full_header();
    test_queue_fill();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
